// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit.
//   MD_MULT / MD_MULTU / MD_DIV / MD_DIVU : 2-bit op encodings on the op port.
//   md_state_t                            : sequencing states of mult_div_unit.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } md_state_t;

endpackage

// File: rtl/md_abs_neg.sv
// Conditional two's-complement negate.
// Used both to take operand magnitudes and to restore result signs.
//   neg  : 1 = output the two's-complement negation of din, 0 = pass through
//   din  : WIDTH-bit input
//   dout : WIDTH-bit result
module md_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    always_comb begin
        dout = neg ? (~din + WIDTH'(1)) : din;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative integer multiply/divide unit with architectural HI/LO registers.
// One result bit per cycle: shift-add multiply, restoring divide. Signed ops
// work on magnitudes; the sign is restored in the FIX state.
//   clk, rst         : clock, asynchronous active-low reset
//   start, op        : operation request (sampled in IDLE) and its encoding
//   src_a, src_b     : multiplicand/dividend, multiplier/divisor
//   wr_hi, wr_lo,
//   wr_data          : MTHI/MTLO writes, honoured only in IDLE without start
//   busy, done       : not-idle flag, one-cycle completion pulse
//   div_zero         : divide attempted with divisor 0 (valid with done)
//   hi, lo           : HI/LO registers
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    md_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // Multiplicand magnitude for multiply, divisor magnitude for divide.
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;     // product / quotient sign
    logic                 rneg_q, rneg_d;   // remainder sign (dividend sign)
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 op_signed, op_div;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [2*WIDTH-1:0]   prod_fixed;
    logic [WIDTH-1:0]     quo_fixed, rem_fixed;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH-1:0]     div_trial;
    logic                 div_ge;

    assign op_signed = (op == MD_MULT) || (op == MD_DIV);
    assign op_div    = (op == MD_DIV)  || (op == MD_DIVU);

    md_abs_neg #(.WIDTH(WIDTH)) u_abs_a (
        .neg  (op_signed & src_a[WIDTH-1]),
        .din  (src_a),
        .dout (abs_a)
    );

    md_abs_neg #(.WIDTH(WIDTH)) u_abs_b (
        .neg  (op_signed & src_b[WIDTH-1]),
        .din  (src_b),
        .dout (abs_b)
    );

    md_abs_neg #(.WIDTH(2*WIDTH)) u_fix_prod (
        .neg  (neg_q),
        .din  (acc_q),
        .dout (prod_fixed)
    );

    md_abs_neg #(.WIDTH(WIDTH)) u_fix_quo (
        .neg  (neg_q),
        .din  (acc_q[WIDTH-1:0]),
        .dout (quo_fixed)
    );

    md_abs_neg #(.WIDTH(WIDTH)) u_fix_rem (
        .neg  (rneg_q),
        .din  (acc_q[2*WIDTH-1:WIDTH]),
        .dout (rem_fixed)
    );

    always_comb begin
        // Shift-add step: add multiplicand when the current multiplier LSB is set.
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                  + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
        // Restoring step: bring in the next dividend bit and trial-subtract.
        // When the subtraction succeeds the difference is below the divisor,
        // so the low WIDTH bits of the difference are exact.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_trial = div_shift[WIDTH-1:0] - opnd_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d = op_div;
                    neg_d    = op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                    rneg_d   = op_signed & op_div & src_a[WIDTH-1];
                    opnd_d   = op_div ? abs_b : abs_a;
                    acc_d    = {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
                    cnt_d    = CNT_W'(WIDTH - 1);
                    dz_d     = op_div && (src_b == '0);
                    state_d  = (op_div && (src_b == '0)) ? DONE : CALC;
                end else begin
                    if (wr_hi) hi_d = wr_data;
                    if (wr_lo) lo_d = wr_data;
                end
            end
            CALC: begin
                if (is_div_q) begin
                    acc_d = {(div_ge ? div_trial : div_shift[WIDTH-1:0]),
                             acc_q[WIDTH-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = quo_fixed;
                    hi_d = rem_fixed;
                end else begin
                    {hi_d, lo_d} = prod_fixed;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
